// File: rtl/array_collector.sv
// Scalar-to-array collector: packs up to DEPTH elements per frame (store or
// running-sum), supports early close via flush, and hands the frame off under a blocking handshake.
//
// state | meaning
// READ  | accepting elements into arr, b_in_notify=1
// WRITE | frame held on b_out, b_out_notify=1, waiting for consumer
module array_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       b_in,
  input  logic                   b_in_sync,
  output logic                   b_in_notify,
  output logic [DEPTH*WIDTH-1:0] b_out,
  output logic [LW-1:0]          b_out_len,
  input  logic                   b_out_sync,
  output logic                   b_out_notify,
  input  logic                   mode,
  input  logic                   flush,
  output logic [15:0]            frame_cnt
);

  localparam logic [0:0] READ  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

  logic [0:0]       state;
  logic [LW-1:0]    idx;
  logic [LW-1:0]    cnt;
  logic             mode_q;
  logic             xfer;
  logic             eff_mode;
  logic [WIDTH-1:0] arr [DEPTH];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] wdata;

  // Both handshake flags come straight from the state flop, so they can never overlap.
  assign b_out_notify = state[0];
  assign b_in_notify  = ~state[0];

  assign xfer = (state == READ) && b_in_sync;
  assign cnt  = idx + LW'(xfer);

  always_comb begin
    prev = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (idx == LW'(i)) prev = arr[i-1];
    end
    eff_mode = (idx == '0) ? mode : mode_q;
    wdata    = eff_mode ? (prev + b_in) : b_in;
  end

  always_comb begin
    b_out = '0;
    for (int i = 0; i < DEPTH; i++) b_out[i*WIDTH +: WIDTH] = arr[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= READ;
      idx       <= '0;
      mode_q    <= 1'b0;
      b_out_len <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
    end else if (state == READ) begin
      if (xfer) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (idx == LW'(i)) arr[i] <= wdata;
        end
        if (idx == '0) mode_q <= mode;
      end
      if (xfer && (idx == LW'(DEPTH - 1))) begin
        state     <= WRITE;
        b_out_len <= LW'(DEPTH);
      end else if (flush && (cnt != '0)) begin
        // Tail slots may hold a previous frame's data; clear them for a short frame.
        state     <= WRITE;
        b_out_len <= cnt;
        for (int i = 0; i < DEPTH; i++) begin
          if (LW'(i) >= cnt) arr[i] <= '0;
        end
      end else if (xfer) begin
        idx <= cnt;
      end
    end else begin
      if (b_out_sync) begin
        state     <= READ;
        idx       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/array_collector.md
# array_collector

Parametrised array collector. Accepts WIDTH-bit elements one per handshake on `b_in`, packs up to DEPTH of them into an array register, then presents the whole array on `b_out` under a blocking handshake. It sits between a scalar producer and an array consumer on the same `*_sync`/`*_notify` port protocol. It adds three things: configurable width and depth, a running-sum (prefix) mode, and early frame termination via `flush`.

## Interface
Parameters:
- `WIDTH`, 32: element width in bits, ≥1.
- `DEPTH`, 2: elements per frame, ≥2.
- `LW`, `$clog2(DEPTH+1)`: width of length/index fields (derived).

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `b_in` in WIDTH: input element. Valid when `b_in_sync && b_in_notify`.
- `b_in_sync` in 1: producer offers an element this cycle.
- `b_in_notify` out 1: block ready to take an element.
- `b_out` out DEPTH*WIDTH: packed array. Element i is at bits `[i*WIDTH +: WIDTH]`.
- `b_out_len` out LW: number of valid elements in `b_out` (1..DEPTH).
- `b_out_sync` in 1: consumer takes the array this cycle.
- `b_out_notify` out 1: array offered to the consumer.
- `mode` in 1: 0 = store, 1 = prefix sum. Sampled on the first element of each frame.
- `flush` in 1: terminate the current frame early.
- `frame_cnt` out 16: count of completed output transfers. Wraps at 2^16.

## Operation
- Input transfer: cycle with `b_in_notify && b_in_sync`.
- Output transfer: cycle with `b_out_notify && b_out_sync`.
- State machine has two states, READ and WRITE. In READ, `b_in_notify=1` and `b_out_notify=0`. In WRITE, `b_in_notify=0` and `b_out_notify=1`. Both notifies are registered and are never high together.
- READ:
  - Each input transfer writes element `idx` and increments `idx`.
  - Store mode: `arr[idx] <= b_in`.
  - Prefix mode: `arr[0] <= b_in`, and for `idx>0`, `arr[idx] <= arr[idx-1] + b_in`, modulo 2^WIDTH (two's-complement wrap, no saturation).
  - When `idx == 0` at a transfer, `mode` is latched into `mode_q` for the frame. Changes to `mode` mid-frame are ignored.
- READ to WRITE, normal: input transfer with `idx == DEPTH-1`. Set `b_out_len <= DEPTH`.
- READ to WRITE, flush: `flush=1` while `idx > 0`. Set `b_out_len <=` element count including any same-cycle transfer. Zero elements `b_out_len..DEPTH-1`.
- `flush` with `idx == 0` and no same-cycle transfer is ignored; empty frames are never emitted.
- `flush` together with a transfer at `idx == 0` closes a 1-element frame.
- `flush` together with the last element (`idx == DEPTH-1`) behaves as a normal full frame.
- `flush` in WRITE is ignored.
- WRITE:
  - `b_out` and `b_out_len` stay stable until the output transfer.
  - On the output transfer: go to READ, `idx <= 0`, `frame_cnt <= frame_cnt+1`.
  - `arr` is not cleared. Stale elements are overwritten by the next frame or zeroed by a flush.
- `b_in_sync` in WRITE and `b_out_sync` in READ are ignored.

## Timing
- Reset (`rst_n=0`, acts immediately, asynchronously):
  - `b_in_notify=1`, `b_out_notify=0`.
  - `b_out=0`, `b_out_len=0`, `frame_cnt=0`.
  - `idx=0`, `mode_q=0`, state READ.
- Reset mid-frame discards partial data with no output. Reset in WRITE drops the pending array.
- First element is accepted at the first rising edge after `rst_n` deasserts with `b_in_sync=1`.
- Last input transfer at edge t: `b_out_notify=1` and `b_out` valid after t.
- Output transfer at edge t: `b_in_notify=1` after t, and `frame_cnt` increments at t.
- With both partners always synced, a full frame takes DEPTH+1 cycles: DEPTH reads plus 1 write.
- Flush close at edge t: `b_out_notify=1` after t, same as a normal close.
- No combinational path from any input to any output.

## Test plan
- Store, DEPTH=2, WIDTH=32: inputs 5, -3; consumer syncs immediately.
  - Expect `b_out = {-3, 5}` and `b_out_len=2`, with `b_out_notify` high one cycle after the 2nd transfer.
  - Then `b_in_notify` returns one cycle later and `frame_cnt=1`.
- Prefix, DEPTH=4, WIDTH=8: `mode=1`, inputs 100, 100, 100, 1.
  - Expect elements 100, 200, 44 (wrap), 45.
  - Toggling `mode` after the 1st element has no effect.
- Flush, DEPTH=4:
  - Inputs 7, 9, then `flush`: expect `{0, 0, 9, 7}` and `b_out_len=2`.
  - `flush` at `idx==0` alone: no state change.
  - `flush` with the 1st element 3: `b_out_len=1`.
- Backpressure: hold `b_out_sync=0` for 10 cycles in WRITE with `b_in_sync=1`.
  - `b_out` stays constant, no inputs are accepted, and `frame_cnt` is unchanged until the sync.
- Reset: assert `rst_n=0` mid-frame (`idx=1`) and again in WRITE.
  - Outputs take reset values immediately, with no output transfer.
  - The next frame starts at element 0.
- Long run, DEPTH=3: random stall patterns on both sides, 70000 frames.
  - Scoreboard matches every array, and `frame_cnt` wraps to 70000 mod 65536 = 4464.
